// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_disp_pkg;

    localparam int WORD_W      = 32;
    localparam int HOLD_MS_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        URGENT = 2'd2
    } state_t;

    // Bits needed for a counter that runs 0 .. hold-1 (hold >= 2).
    function automatic int cnt_w(input int hold);
        return $clog2(hold);
    endfunction

endpackage

// File: rtl/seg_disp_sched_rr_next_sel.sv
// Round-robin finder: next valid index strictly after cur, wrapping back to cur itself last.
// Latency: combinational.
// Backpressure: none.
module rr_next_sel
    import seg_disp_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] cur,
    output logic [IW-1:0] nxt,
    output logic          any_vld
);

    logic          found;
    logic [IW-1:0] idx;

    // Scan offsets 1..N so cur itself is chosen only when it is the sole valid entry.
    always_comb begin
        nxt     = cur;
        any_vld = |valid;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(cur) + k) % N);
            if (!found && valid[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// Display scheduler: rotates NUM_SRC source words onto one 32-bit display word, with urgent override (SEG_DISP_SCHED_URGENT_EN).
// Latency: src_data to disp_data 1 cycle; advance seen at an edge shows the new word one cycle later.
// Backpressure: none; urgent requester holds urgent_req until the one-cycle urgent_ack.
module seg_disp_sched
    import seg_disp_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int HOLD_MS = HOLD_MS_DEF
) (
    input  logic                        clk_1khz,
    input  logic                        rst,
    input  logic [WORD_W*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic                        urgent_req,
    input  logic [WORD_W-1:0]           urgent_data,
    output logic                        urgent_ack,
    input  logic                        pause,
    input  logic                        next_btn,
    output logic [WORD_W-1:0]           disp_data,
    output logic [$clog2(NUM_SRC)-1:0]  cur_src,
    output logic                        urgent_active
);

    localparam int            IW       = $clog2(NUM_SRC);
    localparam int            CW       = cnt_w(HOLD_MS);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MS - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       cur_d;
    logic [IW-1:0]       sel_cur;
    logic [IW-1:0]       nxt_idx;
    logic                any_vld;
    logic                btn_s, btn_d, btn_rise;
    logic                urg_req_eff;
    logic                urg_grant;
    logic                ack_d;
    logic [WORD_W-1:0]   urg_word;
    logic [WORD_W-1:0]   disp_nxt;
    logic [WORD_W-1:0]   src_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_arr[i] = src_data[WORD_W*i +: WORD_W];
    end

    // From IDLE, searching after the last index yields the lowest valid index.
    assign sel_cur  = (state_q == IDLE) ? IW'(NUM_SRC - 1) : cur_src;
    assign btn_rise = btn_s & ~btn_d;

    rr_next_sel #(.N(NUM_SRC)) u_rr (
        .valid   (src_valid),
        .cur     (sel_cur),
        .nxt     (nxt_idx),
        .any_vld (any_vld)
    );

    // Next-state logic: urgent request beats every advance cause; pause only freezes the count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_src;
        ack_d     = 1'b0;
        urg_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (urg_req_eff) begin
                    state_d   = URGENT;
                    cnt_d     = '0;
                    urg_grant = 1'b1;
                end else if (any_vld) begin
                    state_d = SHOW;
                    cur_d   = nxt_idx;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (urg_req_eff) begin
                    state_d   = URGENT;
                    cnt_d     = '0;
                    urg_grant = 1'b1;
                end else if (!any_vld) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!src_valid[cur_src] || btn_rise ||
                             (cnt_q == CNT_LAST && !pause)) begin
                    cur_d = nxt_idx;
                    cnt_d = '0;
                end else if (!pause) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SEG_DISP_SCHED_URGENT_EN
            URGENT: begin
                if (!urgent_req) begin
                    state_d = any_vld ? SHOW : IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    ack_d   = 1'b1;
                    state_d = any_vld ? SHOW : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Display word follows the state held during the cycle, hence one cycle behind transitions.
    always_comb begin
        disp_nxt = '0;
        case (state_q)
            SHOW:    disp_nxt = src_arr[cur_src];
            URGENT:  disp_nxt = urg_word;
            default: disp_nxt = '0;
        endcase
    end

    // State, counter, source index and button edge registers.
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_src   <= '0;
            btn_s     <= 1'b0;
            btn_d     <= 1'b0;
            disp_data <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_src   <= cur_d;
            btn_s     <= next_btn;
            btn_d     <= btn_s;
            disp_data <= disp_nxt;
        end
    end

`ifdef SEG_DISP_SCHED_URGENT_EN
    logic [WORD_W-1:0] urg_word_q;
    logic              ack_q;

    // Latch the override word on grant; ack is a registered one-cycle pulse.
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            urg_word_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            ack_q <= ack_d;
            if (urg_grant) begin
                urg_word_q <= urgent_data;
            end
        end
    end

    // A request still held in the cycle after ack is not re-granted.
    assign urg_req_eff   = urgent_req & ~ack_q;
    assign urg_word      = urg_word_q;
    assign urgent_ack    = ack_q;
    assign urgent_active = (state_q == URGENT);
`else
    logic unused_urg;

    assign urg_req_eff   = 1'b0;
    assign urg_word      = '0;
    assign urgent_ack    = 1'b0;
    assign urgent_active = 1'b0;
    assign unused_urg    = ^{urgent_req, urgent_data, ack_d, urg_grant};
`endif

endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched with NUM_SRC=4, HOLD_MS=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_disp_sched;

    localparam int NS = 4;
    localparam int HM = 4;

    logic            clk_1khz = 1'b0;
    logic            rst = 1'b1;
    logic [32*NS-1:0] src_data = '0;
    logic [NS-1:0]   src_valid = '0;
    logic            urgent_req = 1'b0;
    logic [31:0]     urgent_data = 32'hDEAD_BEEF;
    logic            urgent_ack;
    logic            pause = 1'b0;
    logic            next_btn = 1'b0;
    logic [31:0]     disp_data;
    logic [1:0]      cur_src;
    logic            urgent_active;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  c;
        logic        cc;
        logic        ak;
        logic        ac;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    seg_disp_sched #(.NUM_SRC(NS), .HOLD_MS(HM)) dut (
        .clk_1khz      (clk_1khz),
        .rst           (rst),
        .src_data      (src_data),
        .src_valid     (src_valid),
        .urgent_req    (urgent_req),
        .urgent_data   (urgent_data),
        .urgent_ack    (urgent_ack),
        .pause         (pause),
        .next_btn      (next_btn),
        .disp_data     (disp_data),
        .cur_src       (cur_src),
        .urgent_active (urgent_active)
    );

    always #5 clk_1khz = ~clk_1khz;

    function automatic logic [31:0] w(input int i);
        return 32'h1111_1111 * (i + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_1khz);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] c, input logic cc,
                        input logic ak, input logic ac);
        exp_t e;
        e = '{d: d, c: c, cc: cc, ak: ak, ac: ac};
        sb.push_back(e);
    endtask

    // Plain rotation from reset release over all-valid sources: edge k=1 is IDLE->SHOW.
    task automatic push_rot(input int n);
        for (int k = 1; k <= n; k++) begin
            push((k == 1) ? 32'h0 : w(((k - 2) / HM) % NS), 2'(((k - 1) / HM) % NS),
                 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic drain(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            n++;
            chk($sformatf("%s[%0d] disp", tag, n), disp_data, e.d);
            if (e.cc) chk($sformatf("%s[%0d] cur", tag, n), {30'b0, cur_src}, {30'b0, e.c});
            chk($sformatf("%s[%0d] ack", tag, n), {31'b0, urgent_ack}, {31'b0, e.ak});
            chk($sformatf("%s[%0d] act", tag, n), {31'b0, urgent_active}, {31'b0, e.ac});
        end
    endtask

    task automatic restart(input logic [NS-1:0] v);
        rst        = 1'b1;
        src_valid  = v;
        pause      = 1'b0;
        next_btn   = 1'b0;
        urgent_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) src_data[32*i +: 32] = w(i);

        // Reset state.
        tick();
        chk("rst disp", disp_data, 32'h0);
        chk("rst cur", {30'b0, cur_src}, 32'h0);
        chk("rst ack", {31'b0, urgent_ack}, 32'h0);
        chk("rst act", {31'b0, urgent_active}, 32'h0);

        // Full rotation, each source held HM cycles, wrapping back to source 0.
        restart(4'b1111);
        push_rot(21);
        drain("rot");

        // Asynchronous reset mid-SHOW.
        rst = 1'b1;
        #1;
        chk("arst disp", disp_data, 32'h0);
        chk("arst cur", {30'b0, cur_src}, 32'h0);

        // Valid drop on the shown source, then all invalid -> IDLE.
        restart(4'b0101);
        push(32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        push(w(0), 2'd0, 1'b1, 1'b0, 1'b0);
        drain("vdrop_a");
        src_valid = 4'b0100;
        push(w(0), 2'd2, 1'b1, 1'b0, 1'b0);
        push(w(2), 2'd2, 1'b1, 1'b0, 1'b0);
        drain("vdrop_b");
        src_valid = 4'b0000;
        push(w(2), 2'd0, 1'b0, 1'b0, 1'b0);
        push(32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        push(32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        drain("idle");

        // Pause holds source 1; a button pulse advances while paused.
        restart(4'b1111);
        push_rot(5);
        drain("pre_pause");
        pause = 1'b1;
        for (int i = 0; i < 10; i++) push(w(1), 2'd1, 1'b1, 1'b0, 1'b0);
        drain("pause");
        next_btn = 1'b1;
        push(w(1), 2'd1, 1'b1, 1'b0, 1'b0);
        drain("btn_a");
        next_btn = 1'b0;
        push(w(1), 2'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(w(2), 2'd2, 1'b1, 1'b0, 1'b0);
        drain("btn_b");
        pause = 1'b0;

`ifdef SEG_DISP_SCHED_URGENT_EN
        // Urgent override mid-SHOW of source 1, request held one extra cycle after ack.
        restart(4'b1111);
        push_rot(6);
        drain("pre_urg");
        urgent_req = 1'b1;
        push(w(1), 2'd1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) push(32'hDEAD_BEEF, 2'd1, 1'b1, 1'b0, 1'b1);
        push(32'hDEAD_BEEF, 2'd1, 1'b1, 1'b1, 1'b0);
        push(w(1), 2'd1, 1'b1, 1'b0, 1'b0);
        drain("urg");
        urgent_req = 1'b0;
        push(w(1), 2'd1, 1'b1, 1'b0, 1'b0);
        push(w(1), 2'd1, 1'b1, 1'b0, 1'b0);
        push(w(1), 2'd2, 1'b1, 1'b0, 1'b0);
        push(w(2), 2'd2, 1'b1, 1'b0, 1'b0);
        drain("urg_resume");

        // Urgent aborted after two cycles: no ack, back to source 1 with fresh hold.
        restart(4'b1111);
        push_rot(5);
        drain("pre_abort");
        urgent_req = 1'b1;
        push(w(1), 2'd1, 1'b1, 1'b0, 1'b1);
        push(32'hDEAD_BEEF, 2'd1, 1'b1, 1'b0, 1'b1);
        drain("abort_a");
        urgent_req = 1'b0;
        push(32'hDEAD_BEEF, 2'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(w(1), 2'd1, 1'b1, 1'b0, 1'b0);
        push(w(1), 2'd2, 1'b1, 1'b0, 1'b0);
        drain("abort_b");

        // Reset during URGENT, then re-grant of a still-held request.
        restart(4'b1111);
        push_rot(5);
        drain("pre_rurg");
        urgent_req = 1'b1;
        push(w(1), 2'd1, 1'b1, 1'b0, 1'b1);
        push(32'hDEAD_BEEF, 2'd1, 1'b1, 1'b0, 1'b1);
        drain("rurg");
        rst = 1'b1;
        #1;
        chk("rurg disp", disp_data, 32'h0);
        chk("rurg act", {31'b0, urgent_active}, 32'h0);
        chk("rurg ack", {31'b0, urgent_ack}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("regrant act", {31'b0, urgent_active}, 32'h1);
        urgent_req = 1'b0;
        tick();
        chk("regrant exit act", {31'b0, urgent_active}, 32'h0);
        chk("regrant exit ack", {31'b0, urgent_ack}, 32'h0);
        chk("regrant exit cur", {30'b0, cur_src}, 32'h0);
`else
        // Override channel disabled: urgent_req has no effect on the rotation.
        restart(4'b1111);
        urgent_req = 1'b1;
        push_rot(13);
        drain("urg_off");
        urgent_req = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
